// File: rtl/qkd_event_writer.sv
// qkd_event_writer: timestamps detector clicks, packs them into 16-bit event words and
// streams them into a two-half ping-pong event memory. Optional `QKD_EVW_FLUSH_EN adds flush.
module qkd_event_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int HALF_WORDS = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [3:0]                  det_pulse,
  input  logic [1:0]                  half_ack,
`ifdef QKD_EVW_FLUSH_EN
  input  logic                        flush,
  output logic [$clog2(HALF_WORDS):0] flush_count,
`endif
  output logic [$clog2(HALF_WORDS):0] mem_address,
  output logic [15:0]                 mem_writedata,
  output logic [1:0]                  mem_byteenable,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic                        mem_clken,
  output logic                        irq,
  output logic [1:0]                  full_flags,
  output logic                        active_half,
  output logic [15:0]                 drop_count
);

  localparam int AW = $clog2(HALF_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR  = AW'(HALF_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, STALL} wr_state_t;

  wr_state_t     state;
  logic [12:0]   ts;
  logic          cap_vld;
  logic [15:0]   cap_word;
  logic [1:0]    id;
  logic          multi;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] wr_ptr;
  logic          push, drop, pop, last, close, flush_close, half_nxt;
  logic [1:0]    flags_nxt;

  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;

  // lowest set detector wins the id field
  always_comb begin
    id = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (det_pulse[i]) id = 2'(i);
  end
  assign multi = |(det_pulse & (det_pulse - 4'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts       <= '0;
      cap_vld  <= 1'b0;
      cap_word <= '0;
    end else begin
      cap_vld <= 1'b0;
      if (enable) begin
        ts <= ts + 13'd1;
        if (det_pulse != 4'd0) begin
          cap_vld  <= 1'b1;
          cap_word <= {multi, id, ts};
        end
      end
    end
  end

  // FIFO occupancy is judged before this edge's pop, so a full FIFO drops even while draining
  assign push    = cap_vld && (cnt != FIFO_FULL);
  assign drop    = cap_vld && (cnt == FIFO_FULL);
  assign pop     = (state == WRITE);
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= cap_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      drop_count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt_nxt;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

`ifdef QKD_EVW_FLUSH_EN
  logic flush_pend, flush_fire;

  // a flush waits for the FIFO to empty; state is WRITE only with words queued, so no pop collides
  assign flush_fire  = (flush_pend || flush) && (cnt == '0);
  assign flush_close = flush_fire && (wr_ptr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend  <= 1'b0;
      flush_count <= '0;
    end else if (flush_fire) begin
      flush_pend  <= 1'b0;
      flush_count <= {1'b0, wr_ptr};
    end else if (flush) begin
      flush_pend  <= 1'b1;
    end
  end
`else
  assign flush_close = 1'b0;
`endif

  assign last  = pop && (wr_ptr == LAST_PTR);
  assign close = last || flush_close;

  // completing a half overrides a same-edge ack of that half
  always_comb begin
    flags_nxt = full_flags & ~half_ack;
    if (close) flags_nxt[active_half] = 1'b1;
    half_nxt = close ? ~active_half : active_half;
  end

  // state looks one edge ahead so the pop decision is already registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      active_half    <= 1'b0;
      full_flags     <= 2'b00;
      irq            <= 1'b0;
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      if (flags_nxt[half_nxt])  state <= STALL;
      else if (cnt_nxt != '0)   state <= WRITE;
      else                      state <= IDLE;
      full_flags     <= flags_nxt;
      active_half    <= half_nxt;
      irq            <= |flags_nxt;
      mem_write      <= pop;
      mem_chipselect <= pop;
      if (pop) begin
        mem_address   <= {active_half, wr_ptr};
        mem_writedata <= fifo_mem[rp];
      end
      if (close)    wr_ptr <= '0;
      else if (pop) wr_ptr <= wr_ptr + AW'(1);
    end
  end

endmodule

// File: doc/qkd_event_writer.md
Name: qkd_event_writer

Overview:
- Capture stage directly upstream of the dual-port event memory in the QKD receiver SoC.
- Timestamps single-photon detector clicks and packs each click into a 16-bit event word.
- Writes event words into the 16-bit port of the memory as a ping-pong buffer: two halves of 1024 words each.
- Interrupts the CPU when a half is full; the CPU drains that half through the memory's 32-bit port and then releases it.

Parameters:
- FIFO_DEPTH, 8, elastic event FIFO depth; power of two, minimum 2.
- HALF_WORDS, 1024, words per ping-pong half; memory spans 2*HALF_WORDS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; level-sensitive.
- det_pulse  in  4  synchronised single-cycle detector clicks, bit i = detector i.
- half_ack  in  2  single-cycle CPU release pulse per half.
- mem_address  out  11  memory word address.
- mem_writedata  out  16  event word.
- mem_byteenable  out  2  constant 2'b11.
- mem_chipselect  out  1  asserted together with mem_write.
- mem_write  out  1  write strobe; the memory accepts a write every cycle, with no wait state.
- mem_clken  out  1  constant 1.
- irq  out  1  high while any half is full.
- full_flags  out  2  per-half full flag.
- active_half  out  1  half currently being filled.
- drop_count  out  16  saturating count of lost events.

Behaviour:
- Reset values: all outputs 0, except mem_byteenable = 2'b11 and mem_clken = 1. Time counter, FIFO, write pointer and flags are all cleared.
- Time counter: 13-bit, free-running while enable = 1, wraps 8191 -> 0. It holds its value while enable = 0.
- Capture, only when enable = 1 and det_pulse != 0:
  - Event word = {multi, id[1:0], ts[12:0]}.
  - id = lowest set bit index of det_pulse.
  - multi = 1 if more than one bit is set.
  - ts = counter value at the sampling edge.
- Capture register pushes into the FIFO one edge later.
- If the FIFO is full at push time, the event is discarded and drop_count increments, saturating at 16'hFFFF.
- Latency: click sampled at edge k, FIFO empty, active half not full -> mem_write = 1 in the cycle after edge k+2, carrying that word.
- Writer FSM has three states:
  - IDLE: FIFO empty -> no write.
  - WRITE: FIFO non-empty and full_flags[active_half] = 0 -> pop one word per cycle and drive mem_address = {active_half, wr_ptr[9:0]}. Write outputs are registered.
  - STALL: full_flags[active_half] = 1 -> no pops. The FIFO backs up, then drops occur. Return to WRITE on release of that half.
- Half completion: the write with wr_ptr = HALF_WORDS-1 has these effects at the same edge:
  - full_flags[active_half] <= 1.
  - active_half toggles.
  - wr_ptr <= 0.
  - Writing continues back-to-back into the other half if it is free.
- Release: half_ack[h] clears full_flags[h] only if it is set; otherwise the pulse is ignored.
  - half_ack on the same edge the half completes: the completion wins and the flag ends set.
  - ack of the stalled half releases the stall, and the next write occurs the following cycle.
- irq = |full_flags, registered.
- enable deasserted mid-run: capture stops at once. The FIFO continues to drain into memory, and wr_ptr and active_half are preserved.
- Asynchronous reset mid-write: outputs go low immediately. Buffered events are lost and not counted as drops.

Optional Feature:
- Macro: QKD_EVW_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit) and output flush_count (11 bits).
  - A flush pulse is held pending until the FIFO is empty.
  - The current half is then closed exactly as in half completion, with flush_count = wr_ptr words written. wr_ptr = 0 closes nothing and flush_count = 0.
- Undefined: no flush port and no flush_count port; halves close only when full.

Test Plan:
- Single click: reset, enable = 1, det_pulse = 4'b0100 when ts = 5 -> one write at address 0, data 16'h4005, two cycles after the sampling edge.
- Multi-click: det_pulse = 4'b1010 -> id = 1, multi = 1, data = 16'hA000 | ts.
- Fill and swap: 1024 clicks -> last write at address 1023, full_flags = 2'b01, irq = 1, active_half = 1, next write at address 1024.
- Overflow: both halves full with no ack, then 20 clicks -> 8 buffered and drop_count = 12. half_ack = 2'b01 -> 8 buffered words written starting at address 0 in consecutive cycles.
- Ack corner cases: half_ack[1] while half 1 is being filled -> ignored. half_ack[0] on the same edge as half 0 completes -> flag stays set.
- Reset and flush: reset_n low mid-burst -> outputs 0 immediately. With QKD_EVW_FLUSH_EN, 300 events then flush -> flush_count = 300, full_flags[0] = 1.
